// File: rtl/audio_bridge_pkg.sv
// Shared register map, field positions and helpers for the audio output bridge.
package audio_bridge_pkg;

    // Register offsets within the decoded page (iomem_addr[7:0])
    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    // STATUS bit positions
    localparam int unsigned ST_LEVEL_LSB = 0;
    localparam int unsigned ST_LEVEL_W   = 8;
    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_UNDER     = 10;
    localparam int unsigned ST_OVER      = 11;
    localparam int unsigned ST_IRQ       = 12;

    // CTRL field positions
    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_WM_LSB = 8;
    localparam int unsigned CTRL_WM_W   = 8;

    // CTRL register contents
    typedef struct packed {
        logic [CTRL_WM_W-1:0] watermark;
        logic                 irq_en;
        logic                 enable;
    } ctrl_t;

    // FIFO level needs one extra bit so that a completely full FIFO is representable
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; flush returns to empty
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/audio_out_bridge.sv
// Memory-mapped multi-channel audio output bridge: CPU fills a frame FIFO, LR clock drains it.
module audio_out_bridge
    import audio_bridge_pkg::*;
#(
    parameter int unsigned BITSIZE   = 16,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  ADDR_PAGE = 8'h05
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         iomem_valid,
    output logic                         iomem_ready,
    input  logic [3:0]                   iomem_wstrb,
    input  logic [31:0]                  iomem_addr,
    input  logic [31:0]                  iomem_wdata,
    output logic [31:0]                  iomem_rdata,
    input  logic                         lrclk,
    output logic [CHANNELS*BITSIZE-1:0]  chan_out,
    output logic                         irq
);
    localparam int unsigned LW  = level_width(DEPTH);
    localparam int unsigned FW  = CHANNELS * BITSIZE;
    localparam int unsigned CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    ctrl_t          ctrl_q;
    logic           under_q;
    logic           over_q;
    logic [CIW-1:0] ch_idx_q;
    logic [FW-1:0]  asm_q;
    logic [FW-1:0]  frame;
    logic [FW-1:0]  fifo_head;
    logic [LW-1:0]  fifo_level;
    logic           fifo_empty;
    logic           fifo_full;
    logic           lr_s1_q;
    logic           lr_s2_q;
    logic           lr_prev_q;
    logic           pop_evt;
    logic           page_hit;
    logic           decode;
    logic           wr_en;
    logic           wr_data;
    logic           wr_status;
    logic           wr_ctrl;
    logic           last_slot;
    logic           fifo_push;
    logic           fifo_pop;
    logic           flush;
    logic           under_set;
    logic           over_set;
    logic [31:0]    status_word;
    logic [31:0]    ctrl_word;
    logic [31:0]    rdata_c;
    logic           unused_bits;

    // Decode once per transaction: the ack cycle blocks a second decode of the same request
    assign page_hit  = (iomem_addr[31:24] == ADDR_PAGE);
    assign decode    = iomem_valid & ~iomem_ready & page_hit;
    assign wr_en     = decode & (|iomem_wstrb);
    assign wr_data   = wr_en & (iomem_addr[7:0] == REG_DATA);
    assign wr_status = wr_en & (iomem_addr[7:0] == REG_STATUS);
    assign wr_ctrl   = wr_en & (iomem_addr[7:0] == REG_CTRL);

    // Frame push happens on the write that fills the last channel slot
    assign last_slot = (ch_idx_q == CIW'(CHANNELS - 1));
    assign fifo_push = wr_data & ctrl_q.enable & last_slot;
    assign flush     = wr_ctrl & ctrl_q.enable & ~iomem_wdata[CTRL_ENABLE];

    // LR rising edge, seen through the synchroniser
    assign pop_evt   = lr_s2_q & ~lr_prev_q;
    assign fifo_pop  = pop_evt & ctrl_q.enable & ~fifo_empty & ~flush;
    assign under_set = pop_evt & ctrl_q.enable & fifo_empty;
    assign over_set  = fifo_push & fifo_full & ~fifo_pop;

    assign irq = ctrl_q.enable & ctrl_q.irq_en & (8'(fifo_level) <= ctrl_q.watermark);

    // Address bits outside the page/offset fields and the upper wdata bits are don't-care
    assign unused_bits = ^{iomem_addr[23:8], iomem_wdata, asm_q};

    // Completed frame: earlier slots from the assembly register, last slot straight from the bus
    always_comb begin
        frame = asm_q;
        frame[(CHANNELS-1)*BITSIZE +: BITSIZE] = iomem_wdata[BITSIZE-1:0];
    end

    // Read data mux
    always_comb begin
        status_word = '0;
        status_word[ST_LEVEL_LSB +: ST_LEVEL_W] = 8'(fifo_level);
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_UNDER] = under_q;
        status_word[ST_OVER]  = over_q;
        status_word[ST_IRQ]   = irq;
        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE] = ctrl_q.enable;
        ctrl_word[CTRL_IRQ_EN] = ctrl_q.irq_en;
        ctrl_word[CTRL_WM_LSB +: CTRL_WM_W] = ctrl_q.watermark;
        case (iomem_addr[7:0])
            REG_STATUS: rdata_c = status_word;
            REG_CTRL:   rdata_c = ctrl_word;
            default:    rdata_c = '0;
        endcase
    end

    // One-cycle acknowledge with registered read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= decode;
            iomem_rdata <= decode ? rdata_c : '0;
        end
    end

    // CTRL register and sticky error flags; a hardware set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_q  <= '0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q.enable    <= iomem_wdata[CTRL_ENABLE];
                ctrl_q.irq_en    <= iomem_wdata[CTRL_IRQ_EN];
                ctrl_q.watermark <= iomem_wdata[CTRL_WM_LSB +: CTRL_WM_W];
            end
            under_q <= under_set | (under_q & ~(wr_status & iomem_wdata[ST_UNDER]));
            over_q  <= over_set  | (over_q  & ~(wr_status & iomem_wdata[ST_OVER]));
        end
    end

    // Channel assembly slots and slot index
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ch_idx_q <= '0;
            asm_q    <= '0;
        end else if (flush) begin
            ch_idx_q <= '0;
        end else if (wr_data && ctrl_q.enable) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (ch_idx_q == CIW'(c)) asm_q[c*BITSIZE +: BITSIZE] <= iomem_wdata[BITSIZE-1:0];
            end
            ch_idx_q <= last_slot ? '0 : ch_idx_q + CIW'(1);
        end
    end

    // LR clock synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            lr_prev_q <= 1'b0;
        end else begin
            lr_s1_q   <= lrclk;
            lr_s2_q   <= lr_s1_q;
            lr_prev_q <= lr_s2_q;
        end
    end

    // Output frame register: loads on pop, clears on flush, otherwise holds
    always_ff @(posedge clk) begin
        if (!resetn) begin
            chan_out <= '0;
        end else if (flush) begin
            chan_out <= '0;
        end else if (fifo_pop) begin
            chan_out <= fifo_head;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (flush),
        .wdata  (frame),
        .rdata  (fifo_head),
        .level  (fifo_level),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule

// File: tb/tb_audio_out_bridge.sv
// Bench for audio_out_bridge: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_audio_out_bridge;
    localparam int unsigned BITSIZE  = 16;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 16;
    localparam logic [7:0]  PAGE     = 8'h05;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        lrclk = 1'b0;
    logic [CHANNELS*BITSIZE-1:0] chan_out;
    logic        irq;

    int tests_run = 0;
    int fails = 0;
    bit chk_on = 1'b0;
    bit rnd_done = 1'b0;

    audio_out_bridge #(
        .BITSIZE   (BITSIZE),
        .CHANNELS  (CHANNELS),
        .DEPTH     (DEPTH),
        .ADDR_PAGE (PAGE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .lrclk       (lrclk),
        .chan_out    (chan_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    logic [15:0] mpart[$];
    logic        m_en = 1'b0;
    logic        m_irqen = 1'b0;
    logic [7:0]  m_wm = 8'h0;
    logic        m_under = 1'b0;
    logic        m_over = 1'b0;
    logic [31:0] m_out = 32'h0;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        lr1 = 1'b0, lr2 = 1'b0, lr3 = 1'b0;

    function automatic logic model_irq();
        return m_en && m_irqen && (mq.size() <= int'(m_wm));
    endfunction

    function automatic logic [31:0] model_status();
        int lvl;
        logic [31:0] s;
        lvl = mq.size();
        s = 32'h0;
        s[7:0] = 8'(lvl);
        s[8]   = (lvl == 0);
        s[9]   = (lvl == int'(DEPTH));
        s[10]  = m_under;
        s[11]  = m_over;
        s[12]  = model_irq();
        return s;
    endfunction

    // Apply each bus transaction and LR edge to the model at the clock edge where it takes effect
    always @(posedge clk) begin : ref_model
        logic dec, wr, pop;
        logic [7:0] off;
        logic [31:0] rd, frame;
        if (!resetn) begin
            mq.delete(); mpart.delete();
            m_en = 0; m_irqen = 0; m_wm = 0; m_under = 0; m_over = 0;
            m_out = 0; m_ready = 0; m_rdata = 0;
            lr1 = 0; lr2 = 0; lr3 = 0;
        end else begin
            dec = iomem_valid && !m_ready && (iomem_addr[31:24] == PAGE);
            wr  = dec && (iomem_wstrb != 4'h0);
            off = iomem_addr[7:0];
            // LR rise first sampled two edges ago -> frame appears at this edge
            pop = lr2 && !lr3;
            lr3 = lr2; lr2 = lr1; lr1 = lrclk;
            rd = 32'h0;
            if (dec && off == 8'h04) rd = model_status();
            if (dec && off == 8'h08) rd = {16'h0, m_wm, 6'h0, m_irqen, m_en};
            if (wr && off == 8'h04) begin
                if (iomem_wdata[10]) m_under = 0;
                if (iomem_wdata[11]) m_over = 0;
            end
            if (pop && m_en) begin
                if (mq.size() > 0) m_out = mq.pop_front();
                else m_under = 1;
            end
            if (wr && off == 8'h00 && m_en) begin
                mpart.push_back(iomem_wdata[15:0]);
                if (mpart.size() == int'(CHANNELS)) begin
                    frame = 32'h0;
                    for (int i = 0; i < int'(CHANNELS); i++) frame[i*BITSIZE +: BITSIZE] = mpart[i];
                    mpart.delete();
                    if (mq.size() < int'(DEPTH)) mq.push_back(frame);
                    else m_over = 1;
                end
            end
            if (wr && off == 8'h08) begin
                if (m_en && !iomem_wdata[0]) begin
                    mq.delete(); mpart.delete(); m_out = 0;
                end
                m_en = iomem_wdata[0]; m_irqen = iomem_wdata[1]; m_wm = iomem_wdata[15:8];
            end
            m_ready = dec;
            m_rdata = rd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("ready", 32'(iomem_ready), 32'(m_ready));
            if (m_ready) check("rdata", iomem_rdata, m_rdata);
            check("chan_out", chan_out, m_out);
            check("irq", 32'(irq), 32'(model_irq()));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic bus(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        int n;
        iomem_addr  = {PAGE, 16'($urandom), off};
        iomem_wdata = d;
        iomem_wstrb = s;
        iomem_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 8);
        if (!iomem_ready) begin
            tests_run++;
            fails++;
            $display("FAIL bus_timeout: offset 0x%02h ready got 0 expected 1", off);
        end
        r = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(off, d, 4'hF, r);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] r);
        bus(off, 32'h0, 4'h0, r);
    endtask

    task automatic push_frame(input logic [15:0] lo, input logic [15:0] hi);
        wr(8'h00, {16'hFFFF, lo});
        wr(8'h00, {16'h0000, hi});
    endtask

    task automatic lr_pulse();
        lrclk = 1'b1;
        repeat (3) @(negedge clk);
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic random_op(input bit fill);
        int sel, wdat;
        logic [31:0] r;
        sel  = $urandom_range(0, 99);
        wdat = fill ? 60 : 25;
        if (sel < wdat)
            bus(8'h00, $urandom, ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), r);
        else if (sel < wdat + 15)
            rd(8'h04, r);
        else if (sel < wdat + 22)
            wr(8'h04, $urandom);
        else if (sel < wdat + 27)
            wr(8'h08, {16'($urandom), 8'($urandom_range(0, 18)), 6'($urandom), 1'($urandom),
                       1'($urandom_range(0, 9) != 0)});
        else if (sel < wdat + 30)
            bus(8'($urandom_range(0, 255)), $urandom, 4'($urandom), r);
        else if (sel < wdat + 33)
            rd(8'h08, r);
        else
            repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        rd(8'h04, r);
        check("reset_status", r, 32'h0000_0100);
        check("reset_chan_out", chan_out, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // Single frame and pop latency
        wr(8'h08, 32'h0401);
        push_frame(16'h1111, 16'h2222);
        lrclk = 1'b1;
        repeat (2) @(negedge clk);
        check("pop_early", chan_out, 32'h0);
        @(negedge clk);
        check("pop_latency", chan_out, 32'h2222_1111);
        check("model_pop", m_out, 32'h2222_1111);
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h04, r);
        check("level_after_pop", r, 32'h0000_0100);

        // Fill, overrun, ordered drain, underrun
        for (int i = 0; i < int'(DEPTH); i++) push_frame(16'(32'h1000 + i), 16'(32'h2000 + i));
        push_frame(16'hDEAD, 16'hBEEF);
        rd(8'h04, r);
        check("full_overrun", r, 32'h0000_0A10);
        check("model_full", model_status(), 32'h0000_0A10);
        for (int i = 0; i < int'(DEPTH); i++) begin
            lr_pulse();
            check("fifo_order", chan_out, {16'(32'h2000 + i), 16'(32'h1000 + i)});
        end
        lr_pulse();
        check("underrun_hold", chan_out, 32'h200F_100F);
        rd(8'h04, r);
        check("underrun_status", r, 32'h0000_0D00);
        wr(8'h04, 32'h0000_0C00);
        rd(8'h04, r);
        check("sticky_clear", r, 32'h0000_0100);

        // Watermark interrupt around level 4/5
        wr(8'h08, 32'h0403);
        check("irq_empty", 32'(irq), 32'h1);
        for (int i = 0; i < 5; i++) push_frame(16'(32'h3000 + i), 16'(32'h4000 + i));
        check("irq_level5", 32'(irq), 32'h0);
        rd(8'h04, r);
        check("status_level5", r, 32'h0000_0005);
        lrclk = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_level4", 32'(irq), 32'h1);
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
        push_frame(16'h3005, 16'h4005);
        check("irq_after_push", 32'(irq), 32'h0);
        repeat (5) lr_pulse();
        wr(8'h08, 32'h0401);

        // Push and pop in the same cycle while full
        for (int i = 0; i < int'(DEPTH); i++) push_frame(16'(32'h5000 + i), 16'(32'h6000 + i));
        wr(8'h00, 32'h7777);
        lrclk = 1'b1;
        repeat (2) @(negedge clk);
        wr(8'h00, 32'h8888);
        rd(8'h04, r);
        check("push_pop_full", r, 32'h0000_0210);
        check("push_pop_out", chan_out, 32'h6000_5000);
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
        repeat (DEPTH) lr_pulse();
        check("push_pop_tail", chan_out, 32'h8888_7777);

        // Disable flushes partial frame and output
        wr(8'h00, 32'h5555);
        wr(8'h08, 32'h0);
        check("flush_out", chan_out, 32'h0);
        rd(8'h04, r);
        check("flush_status", r, 32'h0000_0100);
        wr(8'h08, 32'h0401);
        push_frame(16'hAAAA, 16'hBBBB);
        lr_pulse();
        check("stale_discard", chan_out, 32'hBBBB_AAAA);

        // Foreign page, unmapped offset, write-only DATA
        iomem_addr  = {8'h06, 16'h0, 8'h04};
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("wrong_page_noack", 32'(iomem_ready), 32'h0);
        end
        iomem_valid = 1'b0;
        wr(8'h10, 32'hFFFF_FFFF);
        rd(8'h10, r);
        check("unmapped_read", r, 32'h0);
        rd(8'h00, r);
        check("data_read_zero", r, 32'h0);
        rd(8'h08, r);
        check("ctrl_readback", r, 32'h0000_0401);

        // Reset in the middle of frame assembly
        wr(8'h00, 32'h7777);
        do_reset();
        wr(8'h08, 32'h0401);
        push_frame(16'h1234, 16'h5678);
        lr_pulse();
        check("reset_partial", chan_out, 32'h5678_1234);

        // Random traffic with a free-running LR clock
        fork
            begin
                for (int k = 0; k < 600; k++) random_op(k < 300);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    lrclk = ~lrclk;
                    repeat ($urandom_range(3, 7)) @(negedge clk);
                end
                lrclk = 1'b0;
            end
        join
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    // Hard stop if the sequence never completes
    initial begin
        #500000;
        $display("FAIL watchdog: finished got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/audio_out_bridge.md
# audio_out_bridge

Memory-mapped, multi-channel audio output bridge on the PicoSoC iomem bus. The CPU writes samples into a frame FIFO. Each rising edge of the codec DAC LR clock pops one frame onto parallel outputs that feed `i2s_tx`. A watermark interrupt lets firmware refill in bursts instead of servicing every sample. It generalises the single-register frequency/sample path to N channels with buffering, flow-control status and error reporting.

## Interface
- `BITSIZE`, 16: sample width per channel (≤ 32).
- `CHANNELS`, 2: channels per frame (1–8).
- `DEPTH`, 16: FIFO depth in frames; power of two, 2–128.
- `ADDR_PAGE`, 8'h05: value of `iomem_addr[31:24]` this block decodes.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; all zero means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1.
- `lrclk`  in  1  DAC LR clock; asynchronous to `clk`.
- `chan_out`  out  `CHANNELS*BITSIZE`  current frame; channel 0 in the LSBs.
- `irq`  out  1  level-sensitive watermark interrupt.

## Operation
- Register map (`iomem_addr[7:0]`):
  - 0x00 DATA, write-only; reads return 0.
  - 0x04 STATUS:
    - [7:0] level.
    - [8] empty.
    - [9] full.
    - [10] underrun, sticky.
    - [11] overrun, sticky.
    - [12] irq.
    - Writing 1 to bit 10 or bit 11 clears that bit; all other STATUS bits are read-only.
  - 0x08 CTRL, read/write:
    - [0] enable.
    - [1] irq_en.
    - [15:8] watermark.
  - Any other offset reads 0, ignores writes, and is still acknowledged.
- DATA write with any `wstrb` bit set:
  - `wdata[BITSIZE-1:0]` goes to the assembly slot indexed by `ch_idx`, then `ch_idx` increments.
  - On the write to slot `CHANNELS-1`, `ch_idx` wraps to 0 and the assembled frame is pushed.
  - If the FIFO is full at that point, the frame is dropped and overrun is set.
- DATA writes while enable=0 are ignored.
- Writing CTRL with enable changing from 1 to 0 flushes the FIFO, zeroes `ch_idx` and drives `chan_out` to 0.
- `lrclk` path: 2-flop synchroniser, then a previous-value flop. A rising edge produces a one-`clk` `pop_evt`.
- On `pop_evt` with enable=1:
  - FIFO non-empty: pop the head frame into the `chan_out` register.
  - FIFO empty: hold `chan_out` and set underrun.
- With enable=0, `pop_evt` is ignored.
- `irq` = enable & irq_en & (level ≤ watermark).
- Simultaneous push and pop: both execute and the level is unchanged.
  - A push when full is accepted if a pop occurs in the same cycle.
  - A pop when empty does not bypass a same-cycle push; underrun is set and the pushed frame is stored.
- Simultaneous bus clear of a sticky bit and a hardware set of the same bit: the set wins.

## Timing
- Bus transaction:
  - Decode when `iomem_valid` & !`iomem_ready` & page match.
  - `iomem_ready`=1 on the next cycle, for exactly one cycle, with `iomem_rdata` registered in that same cycle.
  - Side effects occur exactly once per transaction, on the decode edge.
- Push latency: level and full update on the cycle `iomem_ready` is asserted.
- Pop latency: `chan_out` updates 3 `clk` edges after `lrclk` rises (2 for the synchroniser, 1 for the register). It is stable for the whole LR period, provided `clk` ≥ 4× `lrclk`.
- `irq` is combinational from registered state and follows a level change in the same cycle.
- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0, `chan_out`=0, `irq`=0.
  - CTRL=0, stickies=0, FIFO empty, `ch_idx`=0.
  - Synchroniser and previous-value flops=0.
- Reset mid-transaction aborts it with no ack. Reset mid-frame discards the partial assembly.

## Structure
- Package `audio_bridge_pkg`:
  - Register offsets `REG_DATA`, `REG_STATUS`, `REG_CTRL`.
  - STATUS bit indices and CTRL field positions.
  - Level width `$clog2(DEPTH)+1`.
- Sub-module `sync_fifo`, parameters `WIDTH`, `DEPTH`:
  - Synchronous with push/pop/flush inputs and level/empty/full outputs.
  - Pointers one bit wider than the address for the full/empty distinction.
- Top level holds:
  - Bus decode.
  - Assembly slots and `ch_idx`.
  - `lrclk` synchroniser.
  - Sticky flags.
  - The `chan_out` register.

## Test plan
- Reset, then read STATUS → 0x100 (empty); `chan_out`=0; `irq`=0.
- CTRL=0x0401; write 0x1111, 0x2222; pulse `lrclk` → `chan_out`=0x2222_1111 at +3 clk; level back to 0.
- Push 16 frames, then a 17th → STATUS full=1, overrun=1; 16 `lrclk` edges pop frames in order; a 17th edge sets underrun and holds the last frame.
- CTRL=0x0403; level goes 5→4 on one pop → `irq` rises when level=4 and falls after a push.
- Push and `pop_evt` in the same cycle at full → level unchanged; no overrun.
- Write one DATA word, clear enable, re-enable, write 0xAAAA, 0xBBBB → frame 0xBBBB_AAAA is popped; the stale partial frame is discarded.
